// File: rtl/iterative_right_shift_of_n.sv
// Multi-cycle right shifter: shifts an N-bit operand by up to N-1 bits, STEP bits per clock,
// logical or arithmetic, with valid/ready handshakes on both the request and result sides.
module iterative_right_shift_of_n #(
    parameter  int N    = 8,
    parameter  int STEP = 1,
    localparam int W    = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    input  logic [W-1:0] in_shamt,
    input  logic         in_arith,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data
);

    // state | meaning
    // IDLE  | waiting for a request, in_ready high
    // SHIFT | shifting STEP bits per cycle until the remaining count runs out
    // DONE  | result presented, waiting for out_ready
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [W-1:0] STEP_W = W'(STEP);

    logic [1:0]   state;
    logic [1:0]   state_nxt;
    logic [N-1:0] sh_reg;
    logic [N-1:0] sh_nxt;
    logic [W-1:0] remaining;
    logic [W-1:0] remaining_nxt;
    logic         fill;
    logic         fill_nxt;

    logic         last_step;
    logic [W-1:0] k;
    logic [N-1:0] fill_mask;
    logic [N-1:0] shifted;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign out_data  = sh_reg;

    // One shift step: move right by k and replicate the fill bit into the vacated top k bits.
    always_comb begin
        last_step = (remaining <= STEP_W);
        k         = last_step ? remaining : STEP_W;
        fill_mask = fill ? ~({N{1'b1}} >> k) : '0;
        shifted   = (sh_reg >> k) | fill_mask;
    end

    always_comb begin
        state_nxt     = state;
        sh_nxt        = sh_reg;
        remaining_nxt = remaining;
        fill_nxt      = fill;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    sh_nxt        = in_data;
                    remaining_nxt = in_shamt;
                    fill_nxt      = in_arith & in_data[N-1];
                    state_nxt     = (in_shamt != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                sh_nxt        = shifted;
                remaining_nxt = remaining - k;
                if (last_step) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sh_reg    <= '0;
            remaining <= '0;
            fill      <= 1'b0;
        end else begin
            state     <= state_nxt;
            sh_reg    <= sh_nxt;
            remaining <= remaining_nxt;
            fill      <= fill_nxt;
        end
    end

endmodule

// File: tb/tb_iterative_right_shift_of_n.sv
// Bench for iterative_right_shift_of_n: four shifter configurations (N=8 STEP 1/2/3, N=13 STEP 4)
// driven with directed vectors and random operations, checked against a >> / >>> model.
module tb_iterative_right_shift_of_n;

    localparam int NG = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NG-1:0] iv;
    logic [NG-1:0] ia;
    logic [NG-1:0] ordy;
    logic [NG-1:0] ir;
    logic [NG-1:0] ov;
    logic [12:0]   id [NG];
    logic [3:0]    sh [NG];
    logic [12:0]   od [NG];

    int n_cmp = 0;
    int n_bad = 0;

    for (genvar g = 0; g < NG; g++) begin : gen_dut
        localparam int GN = (g == 3) ? 13 : 8;
        localparam int GS = (g == 3) ? 4 : g + 1;
        localparam int GW = $clog2(GN);
        logic [GN-1:0] od_n;
        iterative_right_shift_of_n #(.N(GN), .STEP(GS)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (iv[g]),
            .in_ready  (ir[g]),
            .in_data   (id[g][GN-1:0]),
            .in_shamt  (sh[g][GW-1:0]),
            .in_arith  (ia[g]),
            .out_valid (ov[g]),
            .out_ready (ordy[g]),
            .out_data  (od_n)
        );
        assign od[g] = 13'(od_n);
    end

    function automatic int cfg_n(int g);
        return (g == 3) ? 13 : 8;
    endfunction

    function automatic int cfg_step(int g);
        return (g == 3) ? 4 : g + 1;
    endfunction

    function automatic logic [12:0] model(int n, logic [12:0] d, int s, logic a);
        logic [31:0]        mask;
        logic signed [31:0] v;
        mask = (32'd1 << n) - 32'd1;
        v    = 32'(d) & mask;
        if (a && d[n-1]) v = v | ~mask;
        return 13'((v >>> s) & mask);
    endfunction

    task automatic check_val(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic accept(int g, logic [12:0] d, logic [3:0] s, logic a);
        check_val("in_ready_idle", 32'(ir[g]), 32'd1);
        id[g] = d;
        sh[g] = s;
        ia[g] = a;
        iv[g] = 1'b1;
        @(posedge clk);
        #1;
        // scramble inputs: the block must use only what it sampled at acceptance
        iv[g] = 1'b0;
        id[g] = 13'($urandom);
        sh[g] = 4'($urandom);
        ia[g] = 1'($urandom);
    endtask

    task automatic run_op(int g, logic [12:0] d_in, int s, logic a, int stall, logic pulse, string tag);
        int          n;
        int          st;
        int          lat;
        logic [12:0] d;
        logic [12:0] exp_d;
        logic [12:0] held;
        n     = cfg_n(g);
        st    = cfg_step(g);
        d     = d_in & 13'((32'd1 << n) - 32'd1);
        exp_d = model(n, d, s, a);
        ordy[g] = (stall == 0);
        accept(g, d, 4'(s), a);
        lat = 1;
        while (!ov[g] && lat <= 40) begin
            check_val({tag, "_busy_ir"}, 32'(ir[g]), 32'd0);
            @(posedge clk);
            #1;
            lat++;
        end
        check_val({tag, "_lat"}, 32'(lat), 32'(1 + (s + st - 1) / st));
        check_val({tag, "_data"}, 32'(od[g]), 32'(exp_d));
        held = od[g];
        for (int i = 0; i < stall; i++) begin
            if (pulse && i == 0) begin
                iv[g] = 1'b1;
                id[g] = 13'h1FFF;
                sh[g] = 4'd1;
            end else begin
                iv[g] = 1'b0;
            end
            @(posedge clk);
            #1;
            check_val({tag, "_stall_ov"}, 32'(ov[g]), 32'd1);
            check_val({tag, "_stall_data"}, 32'(od[g]), 32'(held));
            check_val({tag, "_stall_ir"}, 32'(ir[g]), 32'd0);
        end
        iv[g]   = 1'b0;
        ordy[g] = 1'b1;
        @(posedge clk);
        #1;
        ordy[g] = 1'b0;
        check_val({tag, "_ov_drop"}, 32'(ov[g]), 32'd0);
        check_val({tag, "_ir_back"}, 32'(ir[g]), 32'd1);
        if (pulse) begin
            @(posedge clk);
            #1;
            check_val({tag, "_no_accept_ir"}, 32'(ir[g]), 32'd1);
            check_val({tag, "_no_accept_ov"}, 32'(ov[g]), 32'd0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        int g;
        iv   = '0;
        ia   = '0;
        ordy = '0;
        for (int i = 0; i < NG; i++) begin
            id[i] = '0;
            sh[i] = '0;
        end
        rst_n = 1'b0;
        #12;
        for (int i = 0; i < NG; i++) begin
            check_val("rst_ir", 32'(ir[i]), 32'd1);
            check_val("rst_ov", 32'(ov[i]), 32'd0);
            check_val("rst_od", 32'(od[i]), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // directed vectors, N=8 STEP=1
        run_op(0, 13'hB6, 3, 1'b0, 0, 1'b0, "log_b6_3");   // -> 0x16, lat 4
        run_op(0, 13'hB6, 3, 1'b1, 0, 1'b0, "ari_b6_3");   // -> 0xF6, lat 4
        run_op(0, 13'h61, 7, 1'b1, 0, 1'b0, "ari_61_7");   // -> 0x00, lat 8
        // N=8 STEP=3
        run_op(2, 13'hFF, 7, 1'b0, 0, 1'b0, "s3_ff_7");    // -> 0x01, lat 4
        run_op(2, 13'hA5, 0, 1'b0, 0, 1'b0, "s3_a5_0");    // -> 0xA5, lat 1
        // back-pressure with a stray request during the stall
        run_op(0, 13'h3C, 2, 1'b0, 5, 1'b1, "bp_3c_2");    // -> 0x0F, lat 3

        // reset while shifting: no result may ever appear
        ordy[0] = 1'b1;
        accept(0, 13'h96, 4'd6, 1'b0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_val("midrst_ov", 32'(ov[0]), 32'd0);
        check_val("midrst_ir", 32'(ir[0]), 32'd1);
        check_val("midrst_od", 32'(od[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (ov[0]) seen++;
        end
        check_val("midrst_no_result", 32'(seen), 32'd0);
        run_op(0, 13'h80, 1, 1'b1, 0, 1'b0, "rst_next");   // -> 0xC0, lat 2

        for (int i = 0; i < 500; i++) begin
            g = i % NG;
            run_op(g, 13'($urandom), int'($urandom_range(0, cfg_n(g) - 1)), 1'($urandom),
                   int'($urandom_range(0, 3)), 1'b0, "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
